// File: rtl/riscv_pkg.sv
// Shared decode-stage types: the immediate format selector, the
// skid-buffer occupancy encoding and the datapath width check.
package riscv_pkg;

    // Width of the instruction slice handed to the extender: bits [31:7].
    localparam int INSTR_W = 25;

    // Immediate format selector. Encodings 8..15 are illegal and
    // produce imm=0 with the error flag set.
    typedef enum logic [3:0] {
        IMM_R  = 4'd0,
        IMM_I  = 4'd1,
        IMM_S  = 4'd2,
        IMM_B  = 4'd3,
        IMM_U  = 4'd4,
        IMM_J  = 4'd5,
        IMM_Z  = 4'd6,
        IMM_SH = 4'd7
    } imm_type_e;

    // Instruction-format classes as the decoder names them.
    typedef enum logic [2:0] {
        FMT_REG    = 3'd0,
        FMT_IMM    = 3'd1,
        FMT_STORE  = 3'd2,
        FMT_BRANCH = 3'd3,
        FMT_UPPER  = 3'd4,
        FMT_JUMP   = 3'd5,
        FMT_CSRI   = 3'd6,
        FMT_SHIFT  = 3'd7
    } instr_fmt_e;

    // Occupancy of the two-entry output skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_count_e;

    // Decoder format class to immediate selector.
    function automatic imm_type_e fmt_to_imm_type(instr_fmt_e fmt);
        imm_type_e t;
        case (fmt)
            FMT_REG:    t = IMM_R;
            FMT_IMM:    t = IMM_I;
            FMT_STORE:  t = IMM_S;
            FMT_BRANCH: t = IMM_B;
            FMT_UPPER:  t = IMM_U;
            FMT_JUMP:   t = IMM_J;
            FMT_CSRI:   t = IMM_Z;
            FMT_SHIFT:  t = IMM_SH;
            default:    t = IMM_R;
        endcase
        return t;
    endfunction

    // Only RV32 and RV64 datapaths are supported.
    function automatic bit xlen_legal(int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor: (instr[31:7], format) -> (imm, err).
// Shared by the decode pipe and any predecode stage.
module imm_extract
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_type_e          imm_type,
    output logic [XLEN-1:0]    imm,
    output logic               err
);

    if (!xlen_legal(XLEN)) begin : g_xlen_check
        $error("imm_extract: XLEN must be 32 or 64");
    end

    // instr[k] here is bit k+7 of the instruction word, so bit 31 is instr[24].
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[24]}}, instr[24:13]};
    assign imm_s = {{20{instr[24]}}, instr[24:18], instr[4:0]};
    assign imm_b = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
    assign imm_u = {instr[24:5], 12'b0};
    assign imm_j = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};

    function automatic logic [XLEN-1:0] sext32(logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Format mux; unknown selectors give a clean zero plus the error flag.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (imm_type)
            IMM_R: imm = '0;
            IMM_I: imm = sext32(imm_i);
            IMM_S: imm = sext32(imm_s);
            IMM_B: imm = sext32(imm_b);
            IMM_U: imm = sext32(imm_u);
            IMM_J: imm = sext32(imm_j);
            IMM_Z: imm = XLEN'(instr[12:8]);
            IMM_SH: begin
                if (XLEN == 32) begin
                    // shamt[5] set is illegal on RV32
                    imm = XLEN'(instr[17:13]);
                    err = instr[18];
                end else begin
                    imm = XLEN'(instr[18:13]);
                end
            end
            default: begin
                imm = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extractor feeding a two-entry skid
// buffer with flush, sideband tag and a saturating error counter.
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  imm_type_e          in_type,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_err,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CNT_W-1:0]   err_count
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [XLEN-1:0]  imm;
    } entry_t;

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;
    entry_t          new_entry;
    entry_t          head_q;
    entry_t          tail_q;
    buf_count_e      count_q;
    logic [CNT_W-1:0] err_count_q;
    logic            accept;
    logic            pop;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr    (in_instr),
        .imm_type (in_type),
        .imm      (ext_imm),
        .err      (ext_err)
    );

    assign new_entry = '{tag: in_tag, err: ext_err, imm: ext_imm};

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = rst_n && (count_q != TWO);
    assign out_valid = (count_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm   = head_q.imm;
    assign out_err   = head_q.err;
    assign out_tag   = head_q.tag;
    assign err_count = err_count_q;

    // Skid buffer: head is always the oldest entry; flush empties it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush) begin
            count_q <= EMPTY;
        end else begin
            case (count_q)
                EMPTY: begin
                    if (accept) begin
                        head_q  <= new_entry;
                        count_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        tail_q  <= new_entry;
                        count_q <= TWO;
                    end else if (pop && !accept) begin
                        count_q <= EMPTY;
                    end else if (accept && pop) begin
                        head_q  <= new_entry;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= ONE;
                    end
                end
                default: count_q <= EMPTY;
            endcase
        end
    end

    // Count accepted error entries; flushed accepts do not count, flush keeps the total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (accept && new_entry.err && !flush && (err_count_q != '1)) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: one RV32 instance (2-bit error counter) and one RV64
// instance share stimulus; a negedge monitor pops expected entries.
module tb_imm_gen_pipe;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, flush, in_valid, out_ready;
    logic [INSTR_W-1:0] in_instr;
    imm_type_e          in_type;
    logic [7:0]         in_tag;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic [1:0]  err_count32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;
    logic [15:0] err_count64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_err(out_err32), .out_tag(out_tag32),
        .err_count(err_count32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_err(out_err64), .out_tag(out_tag64),
        .err_count(err_count64)
    );

    typedef struct {
        logic [31:0] imm32;
        logic        err32;
        logic [63:0] imm64;
        logic        err64;
        logic [7:0]  tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cnt32_m = 0;
    int unsigned cnt64_m = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: occupancy, counters and popped entries against the scoreboard.
    always @(negedge clk) begin
        chk("valid32", 64'(out_valid32), 64'(sb.size() != 0));
        chk("valid64", 64'(out_valid64), 64'(sb.size() != 0));
        chk("errcnt32", 64'(err_count32), 64'(cnt32_m));
        chk("errcnt64", 64'(err_count64), 64'(cnt64_m));
        if (out_valid32 && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out tag=%0h", out_tag32);
            end else begin
                mon_e = sb.pop_front();
                chk("imm32", 64'(out_imm32), 64'(mon_e.imm32));
                chk("err32", 64'(out_err32), 64'(mon_e.err32));
                chk("tag32", 64'(out_tag32), 64'(mon_e.tag));
                chk("imm64", out_imm64, mon_e.imm64);
                chk("err64", 64'(out_err64), 64'(mon_e.err64));
                chk("tag64", 64'(out_tag64), 64'(mon_e.tag));
            end
        end
    end

    // Drive one entry (called just after a posedge); records expectation on accept.
    task automatic push(imm_type_e t, logic [31:0] w, logic [7:0] tag,
                        logic [31:0] e32, logic ee32, logic [63:0] e64, logic ee64);
        logic rdy;
        in_valid = 1'b1;
        in_type  = t;
        in_instr = w[31:7];
        in_tag   = tag;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = in_ready32;
            @(posedge clk);
            #1;
            if (rdy) begin
                sb.push_back('{imm32: e32, err32: ee32, imm64: e64, err64: ee64, tag: tag});
                if (ee32 && cnt32_m < 3) cnt32_m++;
                if (ee64 && cnt64_m < 65535) cnt64_m++;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL push_timeout tag=%0h", tag);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sat_tbl [5];

    initial begin
        sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_type = IMM_R; in_instr = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready32), 64'd0);
        chk("rst_imm32", 64'(out_imm32), 64'd0);
        chk("rst_imm64", out_imm64, 64'd0);
        chk("rst_err", 64'(out_err32), 64'd0);
        chk("rst_tag", 64'(out_tag32), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready32), 64'd1);
        @(posedge clk); #1;

        // Directed formats, back-to-back with out_ready=1
        push(IMM_I,  32'hFFF00093, 8'h11, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        push(IMM_B,  32'hFE000EE3, 8'h12, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        push(IMM_S,  32'hFE000EE3, 8'h13, 32'hFFFFFFFD, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        push(IMM_U,  32'h800000B7, 8'h14, 32'h80000000, 1'b0, 64'hFFFFFFFF_80000000, 1'b0);
        push(IMM_SH, 32'h03F00013, 8'h15, 32'h0000001F, 1'b1, 64'h3F, 1'b0);
        push(IMM_SH, 32'h00500013, 8'h16, 32'h00000005, 1'b0, 64'h05, 1'b0);
        push(IMM_J,  32'hFFDFF06F, 8'h17, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        push(IMM_Z,  32'h800FD073, 8'h18, 32'h0000001F, 1'b0, 64'h1F, 1'b0);
        push(IMM_R,  32'hFFFFFFFF, 8'h19, 32'h0, 1'b0, 64'h0, 1'b0);
        push(imm_type_e'(4'hF), 32'h12345678, 8'h1A, 32'h0, 1'b1, 64'h0, 1'b1);
        push(IMM_I,  32'h7FF00093, 8'h1B, 32'h000007FF, 1'b0, 64'h7FF, 1'b0);
        push(IMM_U,  32'h12345037, 8'h1C, 32'h12345000, 1'b0, 64'h12345000, 1'b0);
        drain();

        // Backpressure: third entry held off until the consumer frees a slot
        out_ready = 1'b0;
        push(IMM_I, 32'h00100093, 8'h01, 32'h1, 1'b0, 64'h1, 1'b0);
        push(IMM_I, 32'h00200093, 8'h02, 32'h2, 1'b0, 64'h2, 1'b0);
        fork
            push(IMM_I, 32'h00300093, 8'h03, 32'h3, 1'b0, 64'h3, 1'b0);
            begin
                @(negedge clk);
                chk("full_in_ready", 64'(in_ready32), 64'd0);
                chk("hold_tag", 64'(out_tag32), 64'h01);
                @(negedge clk);
                chk("full_in_ready2", 64'(in_ready32), 64'd0);
                chk("hold_tag2", 64'(out_tag32), 64'h01);
                chk("hold_imm", 64'(out_imm32), 64'h1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush while full with an incoming entry
        out_ready = 1'b0;
        push(IMM_I, 32'h00400093, 8'h21, 32'h4, 1'b0, 64'h4, 1'b0);
        push(IMM_I, 32'h00500093, 8'h22, 32'h5, 1'b0, 64'h5, 1'b0);
        in_valid = 1'b1; in_type = IMM_I; in_tag = 8'h23; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_valid", 64'(out_valid32), 64'd0);
        chk("flush_in_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Flush with an accepted illegal entry: dropped, not counted
        in_valid = 1'b1; in_type = imm_type_e'(4'hB); in_tag = 8'h24; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Mid-operation reset drops the buffered entry and clears counters
        out_ready = 1'b0;
        push(IMM_I, 32'h00600093, 8'h30, 32'h6, 1'b0, 64'h6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete(); cnt32_m = 0; cnt64_m = 0;
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid32), 64'd0);
        chk("midrst_in_ready", 64'(in_ready32), 64'd0);
        chk("midrst_tag", 64'(out_tag32), 64'd0);
        chk("midrst_imm", 64'(out_imm32), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;

        // Saturating counter on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            push(imm_type_e'(4'h8), 32'hDEADBEEF, 8'(8'h40 + i), 32'h0, 1'b1, 64'h0, 1'b1);
            @(negedge clk);
            chk("sat_cnt", 64'(err_count32), 64'(sat_tbl[i]));
            @(posedge clk); #1;
        end
        drain();
        rst_n = 1'b0;
        @(posedge clk); #1;
        cnt32_m = 0; cnt64_m = 0;
        @(negedge clk);
        chk("rst_cnt32", 64'(err_count32), 64'd0);
        chk("rst_cnt64", 64'(err_count64), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
